dmem_burst_master: RTL and testbench
====================================

DMEM_BURST_MASTER -- requirements
Module: dmem_burst_master

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the width of the word-count field.
REQ-002 Parameter TIMEOUT, default 16, SHALL set the max cycles in WAIT before a grant is declared missing.
REQ-003 clk_i  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 start_i  input  1  SHALL launch a burst when sampled high in IDLE.
REQ-006 dir_i  input  1  SHALL select the burst direction: 0 = read from dmem, 1 = write to dmem.
REQ-007 base_addr_i  input  32  SHALL give the first byte address, in the 0xF------- dmem window.
REQ-008 stride_i  input  32  SHALL give the byte increment between words.
REQ-009 count_i  input  CNT_W  SHALL give the number of words in the burst.
REQ-010 busy_o  output  1  SHALL be high whenever state is not IDLE.
REQ-011 done_o  output  1  SHALL pulse for one cycle at burst end.
REQ-012 err_o  output  1  SHALL be valid with done_o and high on timeout.
REQ-013 wdata_i / wdata_valid_i / wdata_ready_o  in/in/out  32/1/1  SHALL form the write-data stream.
REQ-014 rdata_o / rdata_valid_o / rdata_ready_i  out/out/in  32/1/1  SHALL form the read-data stream.
REQ-015 ext_dmem_req_o, ext_dmem_we_o  output  1 each  SHALL carry the request and write-enable toward dmem.
REQ-016 ext_dmem_addr_o, ext_dmem_wdata_o  output  32 each  SHALL carry the request address and write data.
REQ-017 ext_dmem_gnt_i, ext_dmem_valid_i  input  1 each  SHALL carry the grant and response-valid from dmem.
REQ-018 ext_dmem_rdata_i  input  32  SHALL carry the read data returned from dmem.

Function
REQ-019 The FSM SHALL have states IDLE, FETCH, REQ, WAIT, OUT and DONE.
REQ-020 IDLE + start_i:
- count_i==0 -> DONE;
- dir_i=1 -> FETCH;
- dir_i=0 -> REQ;
- on exit, latch addr=base_addr_i, stride, remaining=count_i and dir.
REQ-021 start_i SHALL be ignored outside IDLE.
REQ-022 FETCH:
- wdata_ready_o=1;
- on wdata_valid_i, capture wdata_i into the write register -> REQ;
- wdata_ready_o SHALL be 0 in all other states.
REQ-023 REQ:
- ext_dmem_req_o=1 for exactly one cycle;
- addr_o=addr, we_o=dir, wdata_o=write register;
- unconditional -> WAIT.
REQ-024 ext_dmem_req_o SHALL never be high in two consecutive cycles; one request per word.
REQ-025 ext_dmem_addr_o, we_o and wdata_o SHALL hold their last values outside REQ.
REQ-026 WAIT, on ext_dmem_gnt_i:
- addr += stride, modulo 2^32 wrap;
- remaining -= 1;
- timeout counter cleared.
REQ-027 WAIT + gnt, read burst:
- capture ext_dmem_rdata_i into rdata_o in the same cycle gnt is seen (gnt and valid arrive together);
- -> OUT.
REQ-028 WAIT + gnt, write burst: remaining (after decrement) ==0 -> DONE, else -> FETCH.
REQ-029 WAIT without gnt:
- increment the timeout counter;
- on reaching TIMEOUT-1 with no gnt -> DONE with error flag set;
- no retry.
REQ-030 OUT:
- rdata_valid_o=1, rdata_o stable;
- on rdata_ready_i: remaining==0 -> DONE, else -> REQ.
REQ-031 rdata_valid_o SHALL be 0 outside OUT.
REQ-032 DONE:
- done_o=1 for one cycle;
- err_o = error flag;
- -> IDLE;
- error flag cleared on the next start.
REQ-033 ext_dmem_valid_i without a prior gnt in WAIT SHALL be ignored.
REQ-034 gnt arriving outside WAIT SHALL be ignored.
REQ-035 Remaining counter SHALL be CNT_W bits and SHALL never underflow.

Reset
REQ-036 On rst_i high, at any point mid-burst:
- state=IDLE;
- ext_dmem_req_o=0, we_o=0, addr_o=0, wdata_o=0;
- busy_o=0, done_o=0, err_o=0;
- rdata_valid_o=0, rdata_o=0, wdata_ready_o=0;
- counters and error flag cleared.
REQ-037 An in-flight request SHALL be abandoned on reset; a late gnt SHALL be ignored.

Verification
REQ-038 Read burst:
- stimulus: base=0xF0000000, stride=4, count=3, gnt+rdata returned one cycle after each req, rdata_ready_i=1;
- response: req pulses at addrs 0xF0000000/04/08, rdata_o 3 words in order, done_o=1, err_o=0;
- timing: first req cycle 1 after start, done cycle 10.
REQ-039 Write burst:
- stimulus: count=2, stride=0x20, wdata stream valid 2 cycles late;
- response: no req before the word is accepted, we_o=1, addrs base and base+0x20, done_o with err_o=0.
REQ-040 Backpressure: rdata_ready_i low 5 cycles on word 1 -> rdata_o stable, no new req until accepted.
REQ-041 Timeout: gnt never asserted, TIMEOUT=16 -> one req only, done_o+err_o=1 exactly 16 cycles after the req.
REQ-042 count=0 -> no req, done_o one cycle after start.
REQ-043 Reset and wrap:
- rst_i mid-WAIT with a late gnt -> IDLE, req=0, no done_o;
- base=0xFFFFFFFC, stride=8 -> second addr 0x00000004.

Source files
------------

// File: rtl/dmem_burst_master_if.sv
// Bundle of every non-clock signal of dmem_burst_master: command, status,
// write/read data streams and the dmem request port.
interface dmem_burst_master_if #(
    parameter int CNT_W = 16
);
    // Streams follow valid/ready: a word moves on a rising edge where both are
    // high; valid never waits for ready and data stays stable while stalled.
    logic             start_i;
    logic             dir_i;
    logic [31:0]      base_addr_i;
    logic [31:0]      stride_i;
    logic [CNT_W-1:0] count_i;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic [31:0]      wdata_i;
    logic             wdata_valid_i;
    logic             wdata_ready_o;
    logic [31:0]      rdata_o;
    logic             rdata_valid_o;
    logic             rdata_ready_i;
    logic             ext_dmem_req_o;
    logic             ext_dmem_we_o;
    logic [31:0]      ext_dmem_addr_o;
    logic [31:0]      ext_dmem_wdata_o;
    logic             ext_dmem_gnt_i;
    logic             ext_dmem_valid_i;
    logic [31:0]      ext_dmem_rdata_i;
    logic [2:0]       dbg_state_o;

    modport master (
        input  start_i, dir_i, base_addr_i, stride_i, count_i,
        input  wdata_i, wdata_valid_i, rdata_ready_i,
        input  ext_dmem_gnt_i, ext_dmem_valid_i, ext_dmem_rdata_i,
        output busy_o, done_o, err_o, wdata_ready_o, rdata_o, rdata_valid_o,
        output ext_dmem_req_o, ext_dmem_we_o, ext_dmem_addr_o, ext_dmem_wdata_o,
        output dbg_state_o
    );

    modport slave (
        output start_i, dir_i, base_addr_i, stride_i, count_i,
        output wdata_i, wdata_valid_i, rdata_ready_i,
        output ext_dmem_gnt_i, ext_dmem_valid_i, ext_dmem_rdata_i,
        input  busy_o, done_o, err_o, wdata_ready_o, rdata_o, rdata_valid_o,
        input  ext_dmem_req_o, ext_dmem_we_o, ext_dmem_addr_o, ext_dmem_wdata_o,
        input  dbg_state_o
    );
endinterface

// File: rtl/dmem_burst_master.sv
// Strided burst master: moves count words between the data streams and dmem,
// one request per word, with a grant timeout that aborts the burst.
module dmem_burst_master #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    dmem_burst_master_if.master  bus
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_REQ   = 3'd2,
        S_WAIT  = 3'd3,
        S_OUT   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_addr;
    logic [31:0]      r_stride;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    logic [31:0]      r_addr_hold;
    logic [31:0]      r_wdata_hold;
    logic             r_we_hold;
    logic             r_dir;
    logic             r_err;
    logic [CNT_W-1:0] r_remain;
    logic [TMO_W-1:0] r_tmo;

    logic [CNT_W-1:0] w_remain_dec;
    logic [TMO_W-1:0] w_tmo_inc;
    logic             w_start;
    logic             w_gnt;

    assign w_remain_dec = (r_remain != '0) ? r_remain - 1'b1 : '0;
    assign w_tmo_inc    = r_tmo + 1'b1;
    assign w_start      = (r_state == S_IDLE) && bus.start_i;
    assign w_gnt        = (r_state == S_WAIT) && bus.ext_dmem_gnt_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start_i) begin
                    if (bus.count_i == '0) begin
                        w_next = S_DONE;
                    end else if (bus.dir_i) begin
                        w_next = S_FETCH;
                    end else begin
                        w_next = S_REQ;
                    end
                end
            end
            S_FETCH: if (bus.wdata_valid_i) w_next = S_REQ;
            S_REQ:   w_next = S_WAIT;
            S_WAIT: begin
                if (bus.ext_dmem_gnt_i) begin
                    if (!r_dir) begin
                        w_next = S_OUT;
                    end else if (w_remain_dec == '0) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_FETCH;
                    end
                end else if (w_tmo_inc == TMO_LAST) begin
                    w_next = S_DONE;
                end
            end
            S_OUT: begin
                if (bus.rdata_ready_i) begin
                    w_next = (r_remain == '0) ? S_DONE : S_REQ;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath; the *_hold registers keep the dmem port steady between requests.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr       <= '0;
            r_stride     <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_addr_hold  <= '0;
            r_wdata_hold <= '0;
            r_we_hold    <= 1'b0;
            r_dir        <= 1'b0;
            r_err        <= 1'b0;
            r_remain     <= '0;
            r_tmo        <= '0;
        end else begin
            if (w_start) begin
                r_addr   <= bus.base_addr_i;
                r_stride <= bus.stride_i;
                r_remain <= bus.count_i;
                r_dir    <= bus.dir_i;
                r_err    <= 1'b0;
            end
            if ((r_state == S_FETCH) && bus.wdata_valid_i) begin
                r_wdata <= bus.wdata_i;
            end
            if (r_state == S_REQ) begin
                r_addr_hold  <= r_addr;
                r_we_hold    <= r_dir;
                r_wdata_hold <= r_wdata;
                r_tmo        <= '0;
            end
            if (w_gnt) begin
                r_addr   <= r_addr + r_stride;
                r_remain <= w_remain_dec;
                r_tmo    <= '0;
                if (!r_dir) begin
                    r_rdata <= bus.ext_dmem_rdata_i;
                end
            end else if (r_state == S_WAIT) begin
                r_tmo <= w_tmo_inc;
                if (w_tmo_inc == TMO_LAST) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.busy_o           = (r_state != S_IDLE);
        bus.done_o           = (r_state == S_DONE);
        bus.err_o            = (r_state == S_DONE) && r_err;
        bus.wdata_ready_o    = (r_state == S_FETCH);
        bus.rdata_valid_o    = (r_state == S_OUT);
        bus.rdata_o          = r_rdata;
        bus.ext_dmem_req_o   = (r_state == S_REQ);
        bus.ext_dmem_addr_o  = r_addr_hold;
        bus.ext_dmem_we_o    = r_we_hold;
        bus.ext_dmem_wdata_o = r_wdata_hold;
        bus.dbg_state_o      = r_state;
        if (r_state == S_REQ) begin
            bus.ext_dmem_addr_o  = r_addr;
            bus.ext_dmem_we_o    = r_dir;
            bus.ext_dmem_wdata_o = r_wdata;
        end
    end
endmodule

// File: tb/tb_dmem_burst_master.sv
// Randomised bench for dmem_burst_master: a dmem responder, stream source and
// sink, and an address/data model built from base + k*stride arithmetic.
module tb_dmem_burst_master;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    dmem_burst_master_if #(.CNT_W(16)) bus ();

    dmem_burst_master #(.CNT_W(16), .TIMEOUT(TIMEOUT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.start_i          = 1'b0;
        bus.dir_i            = 1'b0;
        bus.base_addr_i      = '0;
        bus.stride_i         = '0;
        bus.count_i          = '0;
        bus.wdata_i          = '0;
        bus.wdata_valid_i    = 1'b0;
        bus.rdata_ready_i    = 1'b0;
        bus.ext_dmem_gnt_i   = 1'b0;
        bus.ext_dmem_valid_i = 1'b0;
        bus.ext_dmem_rdata_i = '0;
    endtask

    // Runs one burst from a negedge; cycle 0 is the cycle start_i is presented.
    task automatic run_burst(input logic dir, input logic [31:0] base, input logic [31:0] stride,
                             input int count, input bit no_gnt, input int lat_max,
                             input int ready_pct, input int wd_min, input int wd_max,
                             input int bp_word, input int bp_len,
                             input int exp_done, input int exp_first);
        logic [31:0] exp_q[$];
        logic [31:0] rd_q[$];
        logic [31:0] acc_q[$];
        int cyc, n_req, n_exp, rd_taken, gnt_cnt, wdelay, bp_left;
        int done_cyc, req_cyc, first_req;
        logic [31:0] wword, last_addr, last_wdata, prev_data;
        logic last_we, prev_stall, acc_pending, seen_done, prev_req;

        n_exp = (count == 0) ? 0 : (no_gnt ? 1 : count);
        for (int k = 0; k < n_exp; k++) exp_q.push_back(base + stride * 32'(k));
        n_req = 0; rd_taken = 0; gnt_cnt = 0; bp_left = bp_len;
        done_cyc = -1; req_cyc = -1; first_req = -1;
        last_addr = '0; last_wdata = '0; last_we = 1'b0; prev_data = '0;
        prev_stall = 1'b0; acc_pending = 1'b0; seen_done = 1'b0; prev_req = 1'b0;
        wdelay = $urandom_range(wd_max, wd_min);
        wword = $urandom;

        bus.start_i = 1'b1;
        bus.dir_i = dir;
        bus.base_addr_i = base;
        bus.stride_i = stride;
        bus.count_i = 16'(count);
        bus.wdata_valid_i = 1'b0;
        bus.wdata_i = wword;
        bus.rdata_ready_i = 1'b0;
        cyc = 0;
        while (!seen_done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            // Command inputs must be ignored once the burst is running.
            bus.start_i = (cyc == 3) && (count > 0);
            bus.dir_i = 1'($urandom);
            bus.base_addr_i = $urandom;
            bus.stride_i = $urandom;
            bus.count_i = 16'($urandom);

            bus.ext_dmem_gnt_i = 1'b0;
            bus.ext_dmem_valid_i = 1'b0;
            if (gnt_cnt > 0) begin
                gnt_cnt--;
                if (gnt_cnt == 0) begin
                    bus.ext_dmem_gnt_i = 1'b1;
                    bus.ext_dmem_valid_i = 1'b1;
                    bus.ext_dmem_rdata_i = $urandom;
                    if (!dir) rd_q.push_back(bus.ext_dmem_rdata_i);
                end
            end

            if (bus.ext_dmem_req_o) begin
                chk("req_gap", prev_req, 0);
                if (n_req == 0) first_req = cyc;
                req_cyc = cyc;
                if (exp_q.size() == 0) chk("req_extra", bus.ext_dmem_req_o, 0);
                else chk("req_addr", bus.ext_dmem_addr_o, exp_q.pop_front());
                chk("req_we", bus.ext_dmem_we_o, dir);
                if (dir) begin
                    if (acc_q.size() == 0) chk("req_before_wdata", bus.ext_dmem_req_o, 0);
                    else chk("req_wdata", bus.ext_dmem_wdata_o, acc_q.pop_front());
                end else begin
                    chk("req_order", rd_taken, n_req);
                end
                last_addr = bus.ext_dmem_addr_o;
                last_we = bus.ext_dmem_we_o;
                last_wdata = bus.ext_dmem_wdata_o;
                n_req++;
                if (!no_gnt) gnt_cnt = 1 + $urandom_range(lat_max, 0);
            end else if (n_req > 0) begin
                chk("addr_hold", bus.ext_dmem_addr_o, last_addr);
                chk("we_hold", bus.ext_dmem_we_o, last_we);
                chk("wdata_hold", bus.ext_dmem_wdata_o, last_wdata);
            end
            prev_req = bus.ext_dmem_req_o;

            if (dir) begin
                if (acc_pending) begin
                    bus.wdata_valid_i = 1'b0;
                    wdelay = $urandom_range(wd_max, wd_min);
                    wword = $urandom;
                    bus.wdata_i = wword;
                    acc_pending = 1'b0;
                end else if (!bus.wdata_valid_i) begin
                    if (wdelay == 0) bus.wdata_valid_i = 1'b1;
                    else wdelay--;
                end
                if (bus.wdata_valid_i && bus.wdata_ready_o) begin
                    acc_q.push_back(wword);
                    acc_pending = 1'b1;
                end
            end else begin
                chk("wready_in_read", bus.wdata_ready_o, 0);
            end

            if (prev_stall) begin
                chk("rd_hold_valid", bus.rdata_valid_o, 1);
                chk("rd_hold_data", bus.rdata_o, prev_data);
            end
            if (bus.rdata_valid_o && rd_taken == bp_word && bp_left > 0) begin
                bus.rdata_ready_i = 1'b0;
                bp_left--;
            end else begin
                bus.rdata_ready_i = ($urandom_range(99, 0) < ready_pct);
            end
            prev_stall = bus.rdata_valid_o && !bus.rdata_ready_i;
            prev_data = bus.rdata_o;
            if (bus.rdata_valid_o && bus.rdata_ready_i) begin
                if (rd_q.size() == 0) chk("rd_extra", bus.rdata_valid_o, 0);
                else chk("rdata", bus.rdata_o, rd_q.pop_front());
                rd_taken++;
            end

            chk("busy", bus.busy_o, 1);
            if (bus.done_o) begin
                seen_done = 1'b1;
                done_cyc = cyc;
                chk("done_err", bus.err_o, no_gnt && count > 0);
            end
        end
        chk("done_seen", seen_done, 1);
        chk("req_total", n_req, n_exp);
        chk("rd_total", rd_taken, (dir || no_gnt) ? 0 : count);
        if (exp_done >= 0) chk("done_cyc", done_cyc, exp_done);
        if (exp_first >= 0) chk("first_req", first_req, exp_first);
        if (no_gnt && count > 0) chk("tmo_dist", done_cyc - req_cyc, TIMEOUT);
        idle_inputs();
        @(negedge clk);
        chk("done_pulse", bus.done_o, 0);
        chk("busy_idle", bus.busy_o, 0);
    endtask

    initial begin
        logic d;
        int   cnt;
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_err", bus.err_o, 0);
        chk("rst_req", bus.ext_dmem_req_o, 0);
        chk("rst_we", bus.ext_dmem_we_o, 0);
        chk("rst_addr", bus.ext_dmem_addr_o, 0);
        chk("rst_wdata", bus.ext_dmem_wdata_o, 0);
        chk("rst_rvalid", bus.rdata_valid_o, 0);
        chk("rst_rdata", bus.rdata_o, 0);
        chk("rst_wready", bus.wdata_ready_o, 0);

        // Directed read: grant one cycle after each request, sink always ready.
        run_burst(1'b0, 32'hF000_0000, 32'd4, 3, 1'b0, 0, 100, 0, 0, -1, 0, 10, 1);
        // Directed write: write word presented two cycles late.
        run_burst(1'b1, 32'hF000_1000, 32'h20, 2, 1'b0, 0, 100, 2, 2, -1, 0, -1, -1);
        // Backpressure on word 1 for five cycles.
        run_burst(1'b0, 32'hF000_2000, 32'd4, 3, 1'b0, 0, 100, 0, 0, 1, 5, -1, -1);
        // Grant never arrives.
        run_burst(1'b0, 32'hF000_3000, 32'd4, 2, 1'b1, 0, 100, 0, 0, -1, 0, -1, 1);
        // Zero-length burst.
        run_burst(1'b0, 32'hF000_4000, 32'd4, 0, 1'b0, 0, 100, 0, 0, -1, 0, 1, -1);
        // Address wrap past 2^32; the model expects 0x00000004 second.
        run_burst(1'b0, 32'hFFFF_FFFC, 32'd8, 2, 1'b0, 0, 100, 0, 0, -1, 0, -1, 1);

        // Reset while waiting for a grant, then a late grant.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.base_addr_i = 32'hF000_5000;
        bus.stride_i = 32'd4;
        bus.count_i = 16'd3;
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("rstw_req", bus.ext_dmem_req_o, 1);
        @(negedge clk);
        chk("rstw_busy", bus.busy_o, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.ext_dmem_gnt_i = 1'b1;
        bus.ext_dmem_valid_i = 1'b1;
        bus.ext_dmem_rdata_i = 32'hDEAD_BEEF;
        chk("rstw_req0", bus.ext_dmem_req_o, 0);
        chk("rstw_busy0", bus.busy_o, 0);
        chk("rstw_done0", bus.done_o, 0);
        chk("rstw_addr0", bus.ext_dmem_addr_o, 0);
        chk("rstw_rvalid0", bus.rdata_valid_o, 0);
        chk("rstw_rdata0", bus.rdata_o, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.ext_dmem_gnt_i = (i < 2);
            bus.ext_dmem_valid_i = (i < 2);
            chk("late_gnt_done", bus.done_o, 0);
            chk("late_gnt_busy", bus.busy_o, 0);
            chk("late_gnt_req", bus.ext_dmem_req_o, 0);
            chk("late_gnt_rdata", bus.rdata_o, 0);
        end
        idle_inputs();

        // Randomised bursts in both directions.
        for (int i = 0; i < 24; i++) begin
            d = 1'($urandom);
            cnt = $urandom_range(5, 0);
            run_burst(d, {4'hF, 28'($urandom)}, $urandom, cnt, (i % 8 == 7), 3,
                      $urandom_range(100, 40), 0, 3, -1, 0, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
